// File: rtl/i2so_pkg.sv
`default_nettype none
// =============================================================================
// Package     : i2so_pkg
// Description : Shared constants and scheduler state encoding for i2so_sched.
// Revision    : 1.0 - initial release
// =============================================================================
package i2so_pkg;

    localparam int DATA_SIZE        = 32;
    localparam int DEFAULT_HALF_DIV = 40;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_L = 3'd1,
        S_PUSH_L = 3'd2,
        S_WAIT_R = 3'd3,
        S_PUSH_R = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/i2so_sck_gen.sv
`default_nettype none
// =============================================================================
// Module      : i2so_sck_gen
// Description : Programmable serial-clock divider with a one-cycle rising pulse.
// Revision    : 1.0 - initial release
// =============================================================================
module i2so_sck_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] half_div,
    output logic                 sck_inp,
    output logic                 sck_transition
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] w_eff;
    logic                 w_wrap;
    logic                 r_sck;
    logic                 r_sck_d1;
    logic                 r_trans;

    always_comb begin
        w_eff  = (half_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : half_div;
        w_wrap = (r_cnt == (r_div - DIV_WIDTH'(1)));
    end

    // The divisor is only picked up while idle or at a wrap, so a half-period never tears.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_cnt    <= '0;
            r_div    <= w_eff;
            r_sck    <= 1'b0;
            r_sck_d1 <= 1'b0;
            r_trans  <= 1'b0;
        end else begin
            r_sck_d1 <= r_sck;
            r_trans  <= r_sck & ~r_sck_d1;
            if (w_wrap) begin
                r_cnt <= '0;
                r_div <= w_eff;
                r_sck <= ~r_sck;
            end else begin
                r_cnt <= r_cnt + DIV_WIDTH'(1);
            end
        end
    end

    assign sck_inp        = r_sck;
    assign sck_transition = r_trans;

endmodule
`default_nettype wire

// File: rtl/i2so_sched.sv
`default_nettype none
// =============================================================================
// Module      : i2so_sched
// Description : Feeds i2s_out with L/R-interleaved samples, drives sck, counts underruns.
// Revision    : 1.0 - initial release
// =============================================================================
module i2so_sched #(
    parameter int DATA_SIZE  = i2so_pkg::DATA_SIZE,
    parameter int DIV_WIDTH  = 16,
    parameter int UCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  half_div,
    input  logic                  l_rts,
    input  logic [DATA_SIZE-1:0]  l_data,
    output logic                  l_rtr,
    input  logic                  r_rts,
    input  logic [DATA_SIZE-1:0]  r_data,
    output logic                  r_rtr,
    output logic                  filt_rts,
    output logic [DATA_SIZE-1:0]  filt_data,
    input  logic                  filt_rtr,
    output logic                  sck_inp,
    output logic                  sck_transition,
    input  logic                  ro_fifo_underrun,
    input  logic                  clr_underrun,
    output logic [UCNT_WIDTH-1:0] underrun_cnt,
    output logic                  underrun_sticky,
    output logic                  busy
);

    import i2so_pkg::*;

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic [DATA_SIZE-1:0]  r_latch;
    logic [DATA_SIZE-1:0]  r_last;
    logic                  w_push;
    logic                  r_ur_d1;
    logic                  w_ur_evt;
    logic [UCNT_WIDTH-1:0] r_ucnt;
    logic                  r_sticky;

    i2so_sck_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sck_gen (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .half_div       (half_div),
        .sck_inp        (sck_inp),
        .sck_transition (sck_transition)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Once the left word is taken the pair must finish, so enable is only honoured
    // in WAIT_L and at the end of PUSH_R.
    always_comb begin
        w_next = r_state;
        l_rtr  = 1'b0;
        r_rtr  = 1'b0;
        w_push = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = S_WAIT_L;
                end
            end
            S_WAIT_L: begin
                l_rtr = 1'b1;
                if (l_rts) begin
                    w_next = S_PUSH_L;
                end else if (!enable) begin
                    w_next = S_IDLE;
                end
            end
            S_PUSH_L: begin
                w_push = filt_rtr;
                if (filt_rtr) begin
                    w_next = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                r_rtr = 1'b1;
                if (r_rts) begin
                    w_next = S_PUSH_R;
                end
            end
            S_PUSH_R: begin
                w_push = filt_rtr;
                if (filt_rtr) begin
                    w_next = enable ? S_WAIT_L : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_latch <= '0;
            r_last  <= '0;
        end else begin
            if (l_rtr && l_rts) begin
                r_latch <= l_data;
            end else if (r_rtr && r_rts) begin
                r_latch <= r_data;
            end
            if (w_push) begin
                r_last <= r_latch;
            end
        end
    end

    // Between strobes the bus keeps showing the word that was actually delivered.
    assign filt_rts  = w_push;
    assign filt_data = w_push ? r_latch : r_last;
    assign busy      = (r_state != S_IDLE);

    assign w_ur_evt = enable & ro_fifo_underrun & ~r_ur_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ur_d1  <= 1'b0;
            r_ucnt   <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_ur_d1 <= ro_fifo_underrun;
            if (clr_underrun) begin
                r_ucnt   <= w_ur_evt ? UCNT_WIDTH'(1) : '0;
                r_sticky <= w_ur_evt;
            end else if (w_ur_evt) begin
                if (~&r_ucnt) begin
                    r_ucnt <= r_ucnt + UCNT_WIDTH'(1);
                end
                r_sticky <= 1'b1;
            end
        end
    end

    assign underrun_cnt    = r_ucnt;
    assign underrun_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_i2so_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_i2so_sched
// Description : Randomized and directed self-checking bench for i2so_sched.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_i2so_sched;

    import i2so_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] half_div = 16'(DEFAULT_HALF_DIV);
    logic        l_rts = 1'b0;
    logic [31:0] l_data = '0;
    logic        r_rts = 1'b0;
    logic [31:0] r_data = '0;
    logic        filt_rtr = 1'b1;
    logic        ro_fifo_underrun = 1'b0;
    logic        clr_underrun = 1'b0;

    logic        l_rtr, r_rtr, filt_rts, sck_inp, sck_transition, underrun_sticky, busy;
    logic [31:0] filt_data;
    logic [15:0] underrun_cnt;

    logic        d2_l_rtr, d2_r_rtr, d2_filt_rts, d2_sck, d2_trans, d2_sticky, d2_busy;
    logic [31:0] d2_filt_data;
    logic [1:0]  d2_cnt;

    always #5 clk = ~clk;

    i2so_sched #(.DATA_SIZE(32), .DIV_WIDTH(16), .UCNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .half_div(half_div),
        .l_rts(l_rts), .l_data(l_data), .l_rtr(l_rtr),
        .r_rts(r_rts), .r_data(r_data), .r_rtr(r_rtr),
        .filt_rts(filt_rts), .filt_data(filt_data), .filt_rtr(filt_rtr),
        .sck_inp(sck_inp), .sck_transition(sck_transition),
        .ro_fifo_underrun(ro_fifo_underrun), .clr_underrun(clr_underrun),
        .underrun_cnt(underrun_cnt), .underrun_sticky(underrun_sticky), .busy(busy)
    );

    i2so_sched #(.DATA_SIZE(32), .DIV_WIDTH(16), .UCNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .half_div(half_div),
        .l_rts(l_rts), .l_data(l_data), .l_rtr(d2_l_rtr),
        .r_rts(r_rts), .r_data(r_data), .r_rtr(d2_r_rtr),
        .filt_rts(d2_filt_rts), .filt_data(d2_filt_data), .filt_rtr(filt_rtr),
        .sck_inp(d2_sck), .sck_transition(d2_trans),
        .ro_fifo_underrun(ro_fifo_underrun), .clr_underrun(clr_underrun),
        .underrun_cnt(d2_cnt), .underrun_sticky(d2_sticky), .busy(d2_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pair in progress, which side is owed, and a held word.
    bit          mon_on = 1'b0;
    bit          m_active = 1'b0;
    bit          m_side = 1'b0;
    bit          m_have = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_last = '0;
    int          run = 0;
    bit          m_ur_d = 1'b0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;
    bit          m_sticky = 1'b0;
    logic [31:0] pushed[$];

    always @(negedge clk) begin : mon
        int          eff;
        bit          ev;
        bit          e_push, e_lrtr, e_rrtr, e_sck, e_trans;
        logic [31:0] e_data;
        eff     = (half_div < 16'd2) ? 2 : int'(half_div);
        e_push  = m_have && filt_rtr;
        e_lrtr  = m_active && !m_have && !m_side;
        e_rrtr  = m_active && !m_have && m_side;
        e_data  = e_push ? m_word : m_last;
        e_sck   = ((run / eff) % 2) == 1;
        e_trans = (run > eff) && (((run - 1 - eff) % (2 * eff)) == 0);
        if (mon_on) begin
            chk("busy", busy, m_active);
            chk("l_rtr", l_rtr, e_lrtr);
            chk("r_rtr", r_rtr, e_rrtr);
            chk("filt_rts", filt_rts, e_push);
            chk("filt_data", filt_data, e_data);
            chk("sck_inp", sck_inp, e_sck);
            chk("sck_transition", sck_transition, e_trans);
            chk("underrun_cnt", underrun_cnt, 64'(m_cnt));
            chk("underrun_sticky", underrun_sticky, m_sticky);
            chk("dut2_cnt", d2_cnt, 64'(m_cnt2));
            chk("dut2_sticky", d2_sticky, m_sticky);
            chk("dut2_outputs", {d2_busy, d2_l_rtr, d2_r_rtr, d2_filt_rts, d2_sck, d2_trans, d2_filt_data},
                {m_active, e_lrtr, e_rrtr, e_push, e_sck, e_trans, e_data});
        end
        if (filt_rts) pushed.push_back(filt_data);
        if (rst) begin
            m_active = 0; m_side = 0; m_have = 0; m_last = '0;
            run = 0; m_ur_d = 0; m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
        end else begin
            run = enable ? run + 1 : 0;
            ev  = enable && ro_fifo_underrun && !m_ur_d;
            if (clr_underrun) begin
                m_cnt = ev; m_cnt2 = ev; m_sticky = ev;
            end else if (ev) begin
                m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                m_sticky = 1;
            end
            m_ur_d = ro_fifo_underrun;
            if (!m_active) begin
                if (enable) begin m_active = 1; m_side = 0; end
            end else if (!m_have) begin
                if (!m_side) begin
                    if (l_rts) begin m_have = 1; m_word = l_data; end
                    else if (!enable) m_active = 0;
                end else if (r_rts) begin
                    m_have = 1; m_word = r_data;
                end
            end else if (filt_rtr) begin
                m_last = m_word;
                m_have = 0;
                if (!m_side) m_side = 1;
                else begin m_side = 0; m_active = enable; end
            end
        end
    end

    // Source/sink driver: one call per clock, inputs change 1 time unit after the edge.
    bit          rnd_src = 0, rnd_rtr = 0, rnd_en = 0, rnd_ur = 0;
    logic [31:0] lq[$], rq[$];
    logic [15:0] hd_tab[6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd40};

    task automatic cyc();
        bit hl, hr;
        @(negedge clk);
        hl = l_rts && l_rtr;
        hr = r_rts && r_rtr;
        @(posedge clk);
        #1;
        if (hl && lq.size() > 0) void'(lq.pop_front());
        if (hr && rq.size() > 0) void'(rq.pop_front());
        if (rnd_en) begin
            rst = ($urandom_range(0, 499) == 0);
            if (!enable && $urandom_range(0, 7) == 0) half_div = hd_tab[$urandom_range(0, 5)];
            else if ($urandom_range(0, 63) == 0) enable = !enable;
        end
        if (rnd_rtr) filt_rtr = ($urandom_range(0, 3) != 0);
        if (rnd_ur) begin
            ro_fifo_underrun = 1'($urandom_range(0, 1));
            clr_underrun     = ($urandom_range(0, 15) == 0);
        end
        if (rnd_src) begin
            if (lq.size() < 2) lq.push_back($urandom);
            if (rq.size() < 2) rq.push_back($urandom);
        end
        l_rts  = (lq.size() > 0) && (!rnd_src || $urandom_range(0, 2) != 0);
        l_data = (lq.size() > 0) ? lq[0] : 32'h0;
        r_rts  = (rq.size() > 0) && (!rnd_src || $urandom_range(0, 2) != 0);
        r_data = (rq.size() > 0) ? rq[0] : 32'h0;
    endtask

    initial begin
        int pulses, first, wide, bad;
        bit prev;

        repeat (3) cyc();
        mon_on = 1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_filt_rts", filt_rts, 0);
        chk("rst_filt_data", filt_data, 0);
        chk("rst_sck", sck_inp, 0);
        chk("rst_cnt", underrun_cnt, 0);
        rst = 0;
        repeat (2) cyc();

        // sck divider at half_div=40
        enable = 1;
        pulses = 0; first = -1; wide = 0; prev = 0;
        for (int i = 0; i < 800; i++) begin
            cyc();
            #2;
            if (sck_transition) begin
                pulses++;
                if (first < 0) first = i;
                if (prev) wide++;
            end
            prev = sck_transition;
        end
        chk("t1_pulses", pulses, 10);
        chk("t1_first_pulse", first, 40);
        chk("t1_wide", wide, 0);
        enable = 0;
        repeat (3) cyc();

        // interleaving L then R
        pushed.delete();
        lq = '{32'hFFFFFFFF, 32'h11111111};
        rq = '{32'hAAAAAAAA, 32'h22222222};
        filt_rtr = 1; enable = 1;
        wide = 0; prev = 0;
        for (int g = 0; g < 40 && pushed.size() < 4; g++) begin
            cyc();
            #2;
            if (filt_rts && prev) wide++;
            prev = filt_rts;
        end
        chk("t2_count", pushed.size(), 4);
        if (pushed.size() == 4) begin
            chk("t2_w0", pushed[0], 32'hFFFFFFFF);
            chk("t2_w1", pushed[1], 32'hAAAAAAAA);
            chk("t2_w2", pushed[2], 32'h11111111);
            chk("t2_w3", pushed[3], 32'h22222222);
        end
        chk("t2_wide", wide, 0);
        enable = 0;
        repeat (3) cyc();

        // backpressure in PUSH_L
        pushed.delete();
        filt_rtr = 0; enable = 1;
        lq = '{32'h5A5A5A5A};
        for (int g = 0; g < 20 && lq.size() != 0; g++) cyc();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            #2;
            if (filt_rts || l_rtr || r_rtr) bad++;
        end
        chk("t3_hold", bad, 0);
        filt_rtr = 1;
        #1;
        chk("t3_push_now", filt_rts, 1);
        chk("t3_push_data", filt_data, 32'h5A5A5A5A);
        rq = '{32'hA5A5A5A5};
        for (int g = 0; g < 20 && pushed.size() < 2; g++) cyc();
        chk("t3_count", pushed.size(), 2);
        enable = 0;
        repeat (3) cyc();

        // enable dropped mid-pair
        pushed.delete();
        enable = 1;
        lq = '{32'hCCCCCCCC};
        for (int g = 0; g < 20 && lq.size() != 0; g++) cyc();
        enable = 0;
        rq = '{32'h33333333};
        for (int g = 0; g < 20 && pushed.size() < 2; g++) cyc();
        repeat (2) cyc();
        #2;
        chk("t4_count", pushed.size(), 2);
        if (pushed.size() == 2) begin
            chk("t4_left", pushed[0], 32'hCCCCCCCC);
            chk("t4_right", pushed[1], 32'h33333333);
        end
        chk("t4_busy", busy, 0);
        chk("t4_sck", sck_inp, 0);

        // underrun counting
        enable = 1;
        clr_underrun = 1; cyc(); clr_underrun = 0; cyc();
        for (int k = 0; k < 3; k++) begin
            ro_fifo_underrun = 1; cyc();
            ro_fifo_underrun = 0; cyc();
        end
        #2;
        chk("t5_cnt3", underrun_cnt, 3);
        chk("t5_sticky", underrun_sticky, 1);
        ro_fifo_underrun = 1; clr_underrun = 1; cyc();
        ro_fifo_underrun = 0; clr_underrun = 0; cyc();
        #2;
        chk("t5_clr_evt_cnt", underrun_cnt, 1);
        chk("t5_clr_evt_sticky", underrun_sticky, 1);
        clr_underrun = 1; cyc(); clr_underrun = 0; cyc();
        #2;
        chk("t5_clr_cnt", underrun_cnt, 0);
        chk("t5_clr_sticky", underrun_sticky, 0);
        for (int k = 0; k < 5; k++) begin
            ro_fifo_underrun = 1; cyc();
            ro_fifo_underrun = 0; cyc();
        end
        enable = 0;
        ro_fifo_underrun = 1; cyc();
        ro_fifo_underrun = 0; cyc();
        #2;
        chk("t5_cnt5", underrun_cnt, 5);
        chk("t5_sat2", d2_cnt, 3);

        // reset while in PUSH_R
        pushed.delete();
        enable = 1; filt_rtr = 1;
        lq = '{32'h01010101};
        rq = '{32'hDEADBEEF};
        for (int g = 0; g < 20 && rq.size() != 0; g++) cyc();
        chk("t6_in_push_r", rq.size(), 0);
        filt_rtr = 0; rst = 1;
        cyc();
        rst = 0;
        #2;
        chk("t6_busy", busy, 0);
        chk("t6_outs", {filt_rts, l_rtr, r_rtr, sck_inp, sck_transition, underrun_sticky}, 0);
        chk("t6_data", filt_data, 0);
        chk("t6_cnt", underrun_cnt, 0);
        filt_rtr = 1;
        lq = '{32'h12345678};
        rq = '{32'h87654321};
        for (int g = 0; g < 20 && pushed.size() < 3; g++) cyc();
        chk("t6_count", pushed.size(), 3);
        if (pushed.size() == 3) begin
            chk("t6_new_left", pushed[1], 32'h12345678);
            chk("t6_new_right", pushed[2], 32'h87654321);
        end

        // randomized traffic against the model
        rnd_src = 1; rnd_rtr = 1; rnd_en = 1; rnd_ur = 1;
        for (int i = 0; i < 4000; i++) cyc();
        rnd_src = 0; rnd_rtr = 0; rnd_en = 0; rnd_ur = 0;
        rst = 0; enable = 0; clr_underrun = 0; ro_fifo_underrun = 0;
        repeat (5) cyc();
        mon_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
